// File: rtl/audio_moving_avg_pkg.sv
// Shared definitions for the audio moving-average filter.
//   state_t : controller states (CLEAR sweep, IDLE, FETCH, ACCUM, EMIT)
//   acc_w   : accumulator width that holds the sum of N full-scale samples
package audio_moving_avg_pkg;

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_FETCH,
    ST_ACCUM,
    ST_EMIT
  } state_t;

  function automatic int acc_w(input int data_w, input int log2_n);
    return data_w + log2_n;
  endfunction

endpackage

// File: rtl/audio_moving_avg_delay_line.sv
// Circular delay line for one channel: one write port and a registered read port,
// both addressed by the shared window pointer.
//   i_clk   : clock, rising edge
//   i_we    : write i_wdata to mem[i_addr]
//   i_re    : capture mem[i_addr] into o_rdata on this edge
//   i_addr  : window pointer
//   i_wdata : sample to store
//   o_rdata : registered read data, held until the next i_re
module mavg_delay_line #(
  parameter int DATA_W = 24,
  parameter int LOG2_N = 3
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [LOG2_N-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [2**LOG2_N];
  logic [DATA_W-1:0] r_rdata;

  // No reset on the storage: the controller's CLEAR sweep zeroes it.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/audio_moving_avg.sv
// N-tap moving-average filter between the audio core's ADC-read and DAC-write ports.
// Each channel keeps its own delay line and running sum; output is floor(sum / N),
// or the raw sample when bypass is set.
//   CLOCK_50    : system clock
//   reset       : synchronous, active-high
//   enable      : gate acceptance of new samples
//   bypass      : emit the raw input sample (averaging state still updates)
//   read_ready  : ADC sample available on readdata
//   readdata    : packed input samples, channel 0 in the low DATA_W bits
//   read        : one-cycle pulse consuming readdata
//   write_ready : DAC can accept a sample
//   writedata   : packed output samples, registered
//   write       : one-cycle pulse, writedata valid
//   fill_done   : N samples accepted since reset
module audio_moving_avg
  import audio_moving_avg_pkg::*;
#(
  parameter int DATA_W   = 24,
  parameter int LOG2_N   = 3,
  parameter int CHANNELS = 2
) (
  input  logic                       CLOCK_50,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       bypass,
  input  logic                       read_ready,
  input  logic [CHANNELS*DATA_W-1:0] readdata,
  output logic                       read,
  input  logic                       write_ready,
  output logic [CHANNELS*DATA_W-1:0] writedata,
  output logic                       write,
  output logic                       fill_done
);

  localparam int N     = 1 << LOG2_N;
  localparam int ACC_W = acc_w(DATA_W, LOG2_N);
  localparam int BUS_W = CHANNELS * DATA_W;
  localparam logic [LOG2_N:0] FILL_MAX = (LOG2_N + 1)'(N);

  state_t            r_state, w_state_next;
  logic [LOG2_N-1:0] r_ptr;
  logic [LOG2_N:0]   r_fill_cnt;
  logic [BUS_W-1:0]  r_x;
  logic [BUS_W-1:0]  r_writedata;
  logic [BUS_W-1:0]  w_old_bus;
  logic [BUS_W-1:0]  w_avg;
  logic [BUS_W-1:0]  w_mem_wdata;
  logic              w_mem_we;
  logic              w_mem_re;

  always_comb begin
    w_state_next = r_state;
    read         = 1'b0;
    write        = 1'b0;
    w_mem_we     = 1'b0;
    w_mem_re     = 1'b0;
    w_mem_wdata  = '0;
    case (r_state)
      ST_CLEAR: begin
        w_mem_we = 1'b1;
        if (r_ptr == '1) w_state_next = ST_IDLE;
      end
      ST_IDLE: begin
        if (enable && read_ready) begin
          read         = 1'b1;
          w_mem_re     = 1'b1;
          w_state_next = ST_FETCH;
        end
      end
      ST_FETCH: w_state_next = ST_ACCUM;
      ST_ACCUM: begin
        w_mem_we     = 1'b1;
        w_mem_wdata  = r_x;
        w_state_next = ST_EMIT;
      end
      ST_EMIT: begin
        if (write_ready) begin
          write        = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_CLEAR;
    endcase
    // A pending sample is dropped when reset lands, so no handshake may escape.
    if (reset) begin
      read  = 1'b0;
      write = 1'b0;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state     <= ST_CLEAR;
      r_ptr       <= '0;
      r_fill_cnt  <= '0;
      r_x         <= '0;
      r_writedata <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == ST_CLEAR) r_ptr <= r_ptr + 1'b1;
      if (read) r_x <= readdata;
      if (r_state == ST_ACCUM) begin
        r_ptr <= r_ptr + 1'b1;
        if (r_fill_cnt != FILL_MAX) r_fill_cnt <= r_fill_cnt + 1'b1;
        // Loaded from the next-sum path so writedata is valid on EMIT entry.
        r_writedata <= bypass ? r_x : w_avg;
      end
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic signed [ACC_W-1:0]  r_sum;
    logic signed [ACC_W-1:0]  w_sum_next;
    logic signed [DATA_W-1:0] w_x;
    logic signed [DATA_W-1:0] w_old;

    mavg_delay_line #(
      .DATA_W (DATA_W),
      .LOG2_N (LOG2_N)
    ) u_delay (
      .i_clk   (CLOCK_50),
      .i_we    (w_mem_we),
      .i_re    (w_mem_re),
      .i_addr  (r_ptr),
      .i_wdata (w_mem_wdata[c*DATA_W +: DATA_W]),
      .o_rdata (w_old_bus[c*DATA_W +: DATA_W])
    );

    assign w_x        = r_x[c*DATA_W +: DATA_W];
    assign w_old      = w_old_bus[c*DATA_W +: DATA_W];
    assign w_sum_next = r_sum + ACC_W'(w_x) - ACC_W'(w_old);
    // Upper DATA_W bits of the sum are exactly sum >>> LOG2_N (floor division).
    assign w_avg[c*DATA_W +: DATA_W] = w_sum_next[ACC_W-1:LOG2_N];

    always_ff @(posedge CLOCK_50) begin
      if (reset) r_sum <= '0;
      else if (r_state == ST_ACCUM) r_sum <= w_sum_next;
    end
  end

  assign writedata = r_writedata;
  assign fill_done = (r_fill_cnt == FILL_MAX);

endmodule

// File: tb/tb_audio_moving_avg.sv
module tb_audio_moving_avg;

  localparam int DATA_W   = 24;
  localparam int LOG2_N   = 3;
  localparam int CHANNELS = 2;
  localparam int N        = 1 << LOG2_N;
  localparam int BUS_W    = CHANNELS * DATA_W;

  logic             CLOCK_50 = 1'b0;
  logic             reset, enable, bypass, read_ready, write_ready;
  logic [BUS_W-1:0] readdata;
  logic             read, write, fill_done;
  logic [BUS_W-1:0] writedata;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;

  // Reference model: window of the last N accepted samples per channel.
  int hist [CHANNELS][N];
  int acc_cnt;
  logic [BUS_W-1:0] last_out;

  audio_moving_avg #(
    .DATA_W   (DATA_W),
    .LOG2_N   (LOG2_N),
    .CHANNELS (CHANNELS)
  ) dut (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .enable      (enable),
    .bypass      (bypass),
    .read_ready  (read_ready),
    .readdata    (readdata),
    .read        (read),
    .write_ready (write_ready),
    .writedata   (writedata),
    .write       (write),
    .fill_done   (fill_done)
  );

  always #5 CLOCK_50 = ~CLOCK_50;
  always @(posedge CLOCK_50) cyc++;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    assert (act === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
  endtask

  function automatic int fdiv(input longint s);
    longint q;
    q = s / N;
    if ((s % N) != 0 && s < 0) q--;
    return int'(q);
  endfunction

  function automatic logic [BUS_W-1:0] pack(input int l, input int r);
    logic [DATA_W-1:0] a, b;
    a = DATA_W'(l);
    b = DATA_W'(r);
    return {b, a};
  endfunction

  task automatic model_clear();
    for (int c = 0; c < CHANNELS; c++)
      for (int k = 0; k < N; k++) hist[c][k] = 0;
    acc_cnt = 0;
  endtask

  task automatic model_push(input logic [BUS_W-1:0] din, input bit bp, output logic [BUS_W-1:0] exp);
    logic signed [DATA_W-1:0] s;
    longint sum;
    for (int c = 0; c < CHANNELS; c++) begin
      s = din[c*DATA_W +: DATA_W];
      for (int k = N - 1; k > 0; k--) hist[c][k] = hist[c][k-1];
      hist[c][0] = int'(s);
      sum = 0;
      for (int k = 0; k < N; k++) sum += hist[c][k];
      exp[c*DATA_W +: DATA_W] = bp ? din[c*DATA_W +: DATA_W] : DATA_W'(fdiv(sum));
    end
    acc_cnt++;
  endtask

  // Entered and left at 1 time unit after a rising edge.
  task automatic do_reset();
    reset = 1'b1; read_ready = 1'b0; write_ready = 1'b1; enable = 1'b1; bypass = 1'b0;
    @(posedge CLOCK_50); #1;
    @(negedge CLOCK_50);
    check("rst_read", read, 0);
    check("rst_write", write, 0);
    check("rst_writedata", writedata, 0);
    check("rst_fill_done", fill_done, 0);
    @(posedge CLOCK_50); #1;
    reset = 1'b0;
    model_clear();
  endtask

  // One sample handshake; returns output, read-to-write latency and edges waited for read.
  task automatic xfer(input logic [BUS_W-1:0] din, input int stall,
                      output logic [BUS_W-1:0] dout, output int lat, output int wait_n);
    bit ok, stray, stable;
    int t_rd;
    logic [BUS_W-1:0] wd0;
    readdata = din; read_ready = 1'b1; write_ready = (stall == 0);
    ok = 0; stray = 0; wait_n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLOCK_50);
      wait_n++;
      if (write) stray = 1;
      if (read) begin ok = 1; break; end
    end
    check("read_seen", ok, 1);
    check("no_write_before_read", stray, 0);
    t_rd = cyc;
    @(posedge CLOCK_50); #1;
    read_ready = 1'b0;
    readdata = BUS_W'({$urandom(), $urandom()});
    if (stall > 0) begin
      @(negedge CLOCK_50);
      @(negedge CLOCK_50);
      stable = 1;
      wd0 = '0;
      for (int i = 0; i < stall; i++) begin
        @(negedge CLOCK_50);
        if (i == 0) wd0 = writedata;
        if (write || read || writedata !== wd0) stable = 0;
      end
      check("stall_hold", stable, 1);
      @(posedge CLOCK_50); #1;
      write_ready = 1'b1;
    end
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLOCK_50);
      if (write) begin ok = 1; break; end
    end
    check("write_seen", ok, 1);
    check("read_write_excl", read, 0);
    dout = writedata;
    if (stall > 0) check("stall_data_stable", dout, wd0);
    lat = cyc - t_rd;
    @(negedge CLOCK_50);
    check("write_one_cycle", write, 0);
    @(posedge CLOCK_50); #1;
  endtask

  task automatic run(input string tag, input logic [BUS_W-1:0] din, input bit bp,
                     input int stall, input int exp_wait);
    logic [BUS_W-1:0] dout, exp;
    int lat, wait_n;
    bypass = bp;
    xfer(din, stall, dout, lat, wait_n);
    model_push(din, bp, exp);
    last_out = dout;
    check(tag, dout, exp);
    check("latency", lat, 3 + stall);
    if (exp_wait > 0) check("read_wait", wait_n, exp_wait);
    check("fill_done", fill_done, acc_cnt >= N);
  endtask

  initial begin
    bit seen;
    logic [BUS_W-1:0] din;
    reset = 1'b1; enable = 1'b1; bypass = 1'b0; read_ready = 1'b0;
    write_ready = 1'b1; readdata = '0;

    // Warm-up sweep then constant input: first read after 8 CLEAR cycles.
    do_reset();
    run("const", pack(800, 800), 0, 0, N + 1);
    check("const_first", last_out, pack(100, 100));
    for (int i = 1; i < 10; i++) run("const", pack(800, 800), 0, 0, 0);
    check("const_final", last_out, pack(800, 800));

    // Impulse on left only; right must stay zero.
    do_reset();
    run("impulse", pack(8000, 0), 0, 0, N + 1);
    check("impulse_first", last_out, pack(1000, 0));
    for (int i = 0; i < 9; i++) run("impulse", pack(0, 0), 0, 0, 0);
    check("impulse_final", last_out, pack(0, 0));

    // Negative sample rounds toward -inf and the sum returns to zero.
    do_reset();
    run("neg", pack(-9, 0), 0, 0, 0);
    check("neg_first", last_out, pack(-2, 0));
    for (int i = 0; i < 9; i++) run("neg", pack(0, 0), 0, 0, 0);
    check("neg_final", last_out, pack(0, 0));

    // enable=0 blocks acceptance.
    @(posedge CLOCK_50); #1;
    enable = 1'b0; read_ready = 1'b1; seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLOCK_50);
      if (read) seen = 1;
    end
    check("enable_gate", seen, 0);
    @(posedge CLOCK_50); #1;
    enable = 1'b1;
    run("enable_resume", pack(1234, -4321), 0, 0, 1);

    // Back-pressure in EMIT.
    run("stall", pack(-5000, 77777), 0, 5, 0);

    // Bypass, then averaged output including the bypassed sample.
    run("bypass", pack(24'h7FFFFF, 24'h7FFFFF), 1, 0, 0);
    check("bypass_raw", last_out, {24'h7FFFFF, 24'h7FFFFF});
    run("post_bypass", pack(16, -16), 0, 0, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 30; i++) begin
      din = BUS_W'({$urandom(), $urandom()});
      run("random", din, ($urandom_range(0, 3) == 0), $urandom_range(0, 2), 0);
    end

    // Reset while a write is pending in EMIT.
    readdata = pack(5555, 6666); read_ready = 1'b1; write_ready = 1'b0; seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLOCK_50);
      if (read) begin seen = 1; break; end
    end
    check("emit_rst_read", seen, 1);
    @(posedge CLOCK_50); #1;
    read_ready = 1'b0;
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    check("emit_rst_pending", write, 0);
    @(posedge CLOCK_50); #1;
    reset = 1'b1; write_ready = 1'b1;
    @(negedge CLOCK_50);
    check("emit_rst_no_write", write, 0);
    @(posedge CLOCK_50); #1;
    @(negedge CLOCK_50);
    check("emit_rst_writedata", writedata, 0);
    check("emit_rst_fill", fill_done, 0);
    check("emit_rst_write", write, 0);
    @(posedge CLOCK_50); #1;
    reset = 1'b0;
    model_clear();
    run("after_rst", pack(-800, 800), 0, 0, N + 1);
    check("after_rst_val", last_out, pack(-100, 100));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
